// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/response handshake
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch-stage side: issues requests, receives responses
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with 2-entry fetch queue and IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCwrite,
  input  logic        IF_IDwrite,
  input  logic        PCSrc,
  input  logic [31:0] BRANCH_TARGET,
  if_stage_if.master  imem,
  output logic [31:0] PC_ID,
  output logic [31:0] INSTRUCTION_ID,
  output logic        VALID_ID
);

  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  count;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];

  logic        accept;
  logic        rsp;
  logic        rsp_keep;
  logic        load;
  logic        pop;
  logic        bypass;
  logic        push;
  logic [1:0]  live;
  logic [31:0] rsp_pc;

  // Only issue while the queue plus in-flight requests leave room for the answer
  assign imem.imem_req  = !reset && PCwrite && !PCSrc &&
                          (({1'b0, outstanding} + {1'b0, count}) < 3'd2);
  assign imem.imem_addr = fetch_pc;

  assign accept   = imem.imem_req && imem.imem_ready;
  // A response with nothing outstanding is a memory protocol error; ignore it
  assign rsp      = imem.imem_rvalid && (outstanding != 2'd0);
  assign rsp_keep = rsp && (drop == 2'd0);

  // Requests are issued at consecutive PCs since the last redirect, and dropped
  // ones are always the oldest, so the oldest live request's PC is recovered
  // from fetch_pc and the number of live requests in flight.
  assign live   = outstanding - drop;
  assign rsp_pc = fetch_pc - {28'd0, live, 2'b00};

  assign load   = IF_IDwrite && !PCSrc;
  assign pop    = load && (count != 2'd0);
  assign bypass = load && (count == 2'd0) && rsp_keep;
  assign push   = rsp_keep && !bypass && !PCSrc;

  // Fetch PC, in-flight request count and post-redirect discard count
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
    end else begin
      if (PCSrc) begin
        fetch_pc <= BRANCH_TARGET;
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (accept && !rsp) begin
        outstanding <= outstanding + 2'd1;
      end else if (!accept && rsp) begin
        outstanding <= outstanding - 2'd1;
      end

      if (PCSrc) begin
        drop <= rsp ? (outstanding - 2'd1) : outstanding;
      end else if (rsp && (drop != 2'd0)) begin
        drop <= drop - 2'd1;
      end
    end
  end

  // Fetch queue: entry 0 is the head; redirect empties it
  always_ff @(posedge clk) begin
    if (reset || PCSrc) begin
      count <= 2'd0;
    end else begin
      case ({pop, push})
        2'b10: begin
          q_pc[0]    <= q_pc[1];
          q_instr[0] <= q_instr[1];
          count      <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) begin
            q_pc[0]    <= rsp_pc;
            q_instr[0] <= imem.imem_rdata;
          end else begin
            q_pc[1]    <= rsp_pc;
            q_instr[1] <= imem.imem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q_pc[0]    <= rsp_pc;
            q_instr[0] <= imem.imem_rdata;
          end else begin
            q_pc[0]    <= q_pc[1];
            q_instr[0] <= q_instr[1];
            q_pc[1]    <= rsp_pc;
            q_instr[1] <= imem.imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // IF/ID register: flush beats stall; queue head beats a bypassed response
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_ID          <= 32'd0;
      INSTRUCTION_ID <= NOP;
      VALID_ID       <= 1'b0;
    end else if (PCSrc) begin
      INSTRUCTION_ID <= NOP;
      VALID_ID       <= 1'b0;
    end else if (IF_IDwrite) begin
      if (pop) begin
        PC_ID          <= q_pc[0];
        INSTRUCTION_ID <= q_instr[0];
        VALID_ID       <= 1'b1;
      end else if (bypass) begin
        PC_ID          <= rsp_pc;
        INSTRUCTION_ID <= imem.imem_rdata;
        VALID_ID       <= 1'b1;
      end else begin
        INSTRUCTION_ID <= NOP;
        VALID_ID       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCwrite = 1'b0;
  logic        IF_IDwrite = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic [31:0] PC_ID, INSTRUCTION_ID;
  logic        VALID_ID;
  logic [31:0] w_pc_id, w_instr_id;
  logic        w_valid_id;

  if_stage_if imem ();
  if_stage_if wmem ();

  if_stage #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite),
    .PCSrc(PCSrc), .BRANCH_TARGET(BRANCH_TARGET), .imem(imem),
    .PC_ID(PC_ID), .INSTRUCTION_ID(INSTRUCTION_ID), .VALID_ID(VALID_ID)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP(NOP)) u_wrap (
    .clk(clk), .reset(reset), .PCwrite(1'b1), .IF_IDwrite(1'b1),
    .PCSrc(1'b0), .BRANCH_TARGET(32'd0), .imem(wmem),
    .PC_ID(w_pc_id), .INSTRUCTION_ID(w_instr_id), .VALID_ID(w_valid_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int delivered = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100;
  logic rst_req = 1'b1;
  exp_t exp_q[$];
  logic [31:0] mem_addr_q[$];
  int mem_due_q[$];
  logic [31:0] model_pc = 32'd0;
  logic prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] mon_pc = 32'd0, mon_instr = NOP;
  logic mon_valid = 1'b0;
  logic w_pend = 1'b0;
  logic [31:0] w_paddr = 32'd0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) | 32'h0000_0003;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive inputs at negedge, play memory, log accepted requests
  task automatic drive_cycle(input logic pcw, input logic ifw, input logic pcs,
                             input logic [31:0] tgt);
    @(negedge clk);
    cyc++;
    reset = rst_req;
    PCwrite = pcw;
    IF_IDwrite = ifw;
    PCSrc = pcs;
    BRANCH_TARGET = tgt;
    if (rst_req) begin
      exp_q.delete();
      mem_addr_q.delete();
      mem_due_q.delete();
      model_pc = 32'd0;
    end
    imem.imem_ready = ($urandom_range(0, 99) < rdy_pct);
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata = word(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata = $urandom;
    end
    if (pcs && !rst_req) begin
      exp_q.delete();
      model_pc = tgt;
    end
    #1;
    if (rst_req) check("req_in_reset", {31'd0, imem.imem_req}, 32'd0);
    if (pcs && !rst_req) check("req_on_redirect", {31'd0, imem.imem_req}, 32'd0);
    if (prev_wait && imem.imem_req) check("addr_stable", imem.imem_addr, prev_addr);
    if (imem.imem_req && imem.imem_ready) begin
      check("fetch_addr", imem.imem_addr, model_pc);
      exp_q.push_back('{model_pc, word(model_pc)});
      mem_addr_q.push_back(imem.imem_addr);
      mem_due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
      model_pc = model_pc + 32'd4;
    end
    prev_wait = imem.imem_req && !imem.imem_ready && !rst_req && !pcs;
    prev_addr = imem.imem_addr;
  endtask

  // Zero-wait memory for the wrap-around instance
  initial begin
    wmem.imem_ready = 1'b1;
    wmem.imem_rvalid = 1'b0;
    wmem.imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      wmem.imem_rvalid = w_pend;
      wmem.imem_rdata = word(w_paddr);
      #1;
      w_pend = wmem.imem_req;
      w_paddr = wmem.imem_addr;
    end
  end

  // Monitor: maintain expected IF/ID contents and pop the scoreboard on each load
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mon_pc = 32'd0; mon_instr = NOP; mon_valid = 1'b0;
    end else if (PCSrc) begin
      mon_instr = NOP; mon_valid = 1'b0;
    end else if (IF_IDwrite) begin
      if (VALID_ID) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pc %h with empty scoreboard (cycle %0d)", PC_ID, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          mon_pc = e.pc; mon_instr = e.instr; mon_valid = 1'b1;
          delivered++;
        end
      end else begin
        mon_instr = NOP; mon_valid = 1'b0;
      end
    end
    check("id_pc", PC_ID, mon_pc);
    check("id_instr", INSTRUCTION_ID, mon_instr);
    check("id_valid", {31'd0, VALID_ID}, {31'd0, mon_valid});
  end

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    rst_req = 1'b0;
  endtask

  initial begin
    int d0;
    int guard;
    logic [31:0] wexp;
    imem.imem_ready = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'd0;

    // Reset, then zero-wait fetch: PC_ID 0,4,8 at cycles 2..4
    do_reset(3);
    check("rst_pc", PC_ID, 32'd0);
    check("rst_instr", INSTRUCTION_ID, NOP);
    check("rst_valid", {31'd0, VALID_ID}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (k >= 2) begin
        check("lat_valid", {31'd0, VALID_ID}, 32'd1);
        check("lat_pc", PC_ID, 32'(4 * (k - 2)));
        wexp = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        check("wrap_pc", w_pc_id, wexp);
        check("wrap_instr", w_instr_id, word(wexp));
      end
    end

    // Stall at PC_ID=8 for 3 cycles, then resume 12,16,20 without gaps
    for (int s = 0; s < 3; s++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      check("stall_pc", PC_ID, 32'd8);
      check("stall_req", {31'd0, imem.imem_req}, 32'd0);
      if (s == 0) begin
        check("wrap_pc_last", w_pc_id, 32'd0);
      end
    end
    for (int r = 0; r < 4; r++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (r >= 1) begin
        check("resume_valid", {31'd0, VALID_ID}, 32'd1);
        check("resume_pc", PC_ID, 32'(12 + 4 * (r - 1)));
      end
    end

    // Decode stalled with fetch enabled: queue fills and requests stop
    for (int s = 0; s < 3; s++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      if (s == 2) check("fifo_full_req", {31'd0, imem.imem_req}, 32'd0);
    end
    for (int r = 0; r < 4; r++) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect to 0x100 with two slow requests in flight
    lat_min = 3; lat_max = 3;
    for (int r = 0; r < 8; r++) drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h100);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("flush_valid", {31'd0, VALID_ID}, 32'd0);
    check("flush_instr", INSTRUCTION_ID, NOP);
    d0 = delivered;
    guard = 0;
    while (delivered == d0 && guard < 50) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      guard++;
    end
    check("redirect_pc", PC_ID, 32'h100);
    for (int r = 0; r < 6; r++) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect coincident with a decode stall still flushes
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h200);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("flush_stall_valid", {31'd0, VALID_ID}, 32'd0);
    for (int r = 0; r < 8; r++) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Toggling ready, 3-cycle latency: PCs 0..40 delivered once each, in order
    do_reset(2);
    rdy_pct = 50;
    d0 = delivered;
    guard = 0;
    while (delivered - d0 < 11 && guard < 400) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      guard++;
    end
    check("toggle_progress", 32'(delivered - d0), 32'd11);

    // Random stalls, redirects and memory timing
    lat_min = 1; lat_max = 3; rdy_pct = 70;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom & 32'hFFFF_FFFC;
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, tgt);
    end

    // Drain: every accepted request must reach IF/ID
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
